// File: rtl/bitn_counter.sv
// rtl/bitn_counter.sv - parametrised up/down modulo counter with prescaler clock-enable
//
// Purpose: counts bit slots, symbol positions or retries for the serial framers.
// The count sequence is 0..modulus. In slow mode the counter only steps once
// every DIV enabled cycles, paced by an internal prescaler.
//
// Parameters:
//   WIDTH     counter width in bits (>= 1)
//   DIV       prescaler divisor for slow mode (>= 2)
// Ports:
//   clk       system clock; all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   en        count enable; the counter and prescaler hold when low
//   fast      1 = step on every enabled cycle, 0 = step on prescaler terminal
//   clr       synchronous clear of counter, prescaler and wrap (highest priority)
//   load      synchronous parallel load of load_val (ignores en)
//   load_val  value for load; it is not clamped to modulus
//   dir       1 = count up, 0 = count down
//   modulus   terminal value
//   cnt       current count (registered)
//   one       cnt == modulus
//   zero      cnt == 0
//   step      the counter advances at the coming edge
//   wrap      one-cycle pulse in the cycle after a wrapping step
module bitn_counter #(
    parameter int WIDTH = 3,
    parameter int DIV   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fast,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] cnt,
    output logic             one,
    output logic             zero,
    output logic             step,
    output logic             wrap
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;
    logic          presc_last;

    assign presc_last = (presc == PW'(DIV - 1));
    assign step       = en & ~clr & ~load & (fast | presc_last);
    assign one        = (cnt == modulus);
    assign zero       = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;

            // Holding presc at 0 in fast mode makes a fast->slow switch
            // start with a full DIV-cycle period.
            if (en) begin
                if (fast || presc_last) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            // Out-of-range counts (e.g. after a load above modulus) are
            // treated as wrapping so natural overflow is never observed.
            if (step) begin
                if (dir) begin
                    if (cnt >= modulus) begin
                        cnt  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end else begin
                    if (cnt == '0 || cnt > modulus) begin
                        cnt  <= modulus;
                        wrap <= 1'b1;
                    end else begin
                        cnt <= cnt - WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bitn_counter.sv
// tb/tb_bitn_counter.sv - directed self-checking bench for bitn_counter
module tb_bitn_counter;

    localparam int WIDTH = 3;
    localparam int DIV   = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             fast;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] cnt;
    logic             one;
    logic             zero;
    logic             step;
    logic             wrap;

    int n_checks = 0;
    int n_errors = 0;

    bitn_counter #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .fast     (fast),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .modulus  (modulus),
        .cnt      (cnt),
        .one      (one),
        .zero     (zero),
        .step     (step),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_dn[7] = '{5, 4, 3, 2, 1, 0, 5};

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        fast     = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        dir      = 1'b1;
        modulus  = 3'd7;
        #12;

        // Reset state
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_one", 32'(one), 0);
        chk("rst_wrap", 32'(wrap), 0);
        modulus = 3'd0;
        #1;
        chk("rst_one_mod0", 32'(one), 1);
        modulus = 3'd7;

        // Fast up-count 0..7,0
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        fast  = 1'b1;
        #1;
        chk("up_step", 32'(step), 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("up_cnt%0d", i), 32'(cnt), 32'(i % 8));
            chk($sformatf("up_one%0d", i), 32'(one), 32'((i % 8) == 7));
            chk($sformatf("up_zero%0d", i), 32'(zero), 32'((i % 8) == 0));
            chk($sformatf("up_wrap%0d", i), 32'(wrap), 32'(i == 8));
        end

        // Down-count with modulus 5 from 0
        modulus = 3'd5;
        dir     = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("dn_cnt%0d", i), 32'(cnt), 32'(exp_dn[i]));
            chk($sformatf("dn_wrap%0d", i), 32'(wrap), 32'(exp_dn[i] == 5));
        end

        // Slow mode from clr
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        fast    = 1'b0;
        dir     = 1'b1;
        modulus = 3'd7;
        chk("clr_cnt", 32'(cnt), 0);
        chk("clr_wrap", 32'(wrap), 0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("slow_step%0d", i), 32'(step), 32'(i == 4));
            tick();
            chk($sformatf("slow_cnt%0d", i), 32'(cnt), 32'(i == 4));
        end
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("slow_hold", 32'(cnt), 1);
        end
        en = 1'b1;
        tick();
        chk("slow_pre", 32'(cnt), 1);
        tick();
        chk("slow_delayed", 32'(cnt), 2);

        // Load out of range then up-step
        fast     = 1'b1;
        modulus  = 3'd3;
        load     = 1'b1;
        load_val = 3'd6;
        #1;
        chk("load_nostep", 32'(step), 0);
        tick();
        load = 1'b0;
        chk("load_cnt", 32'(cnt), 6);
        chk("load_wrap", 32'(wrap), 0);
        tick();
        chk("oor_up_cnt", 32'(cnt), 0);
        chk("oor_up_wrap", 32'(wrap), 1);

        // Load out of range then down-step
        load = 1'b1;
        dir  = 1'b0;
        tick();
        load = 1'b0;
        tick();
        chk("oor_dn_cnt", 32'(cnt), 3);
        chk("oor_dn_wrap", 32'(wrap), 1);

        // Priority: clr beats load and step
        modulus  = 3'd7;
        dir      = 1'b1;
        load     = 1'b1;
        load_val = 3'd4;
        tick();
        chk("pri_pre", 32'(cnt), 4);
        clr      = 1'b1;
        load_val = 3'd2;
        tick();
        chk("pri_clr_cnt", 32'(cnt), 0);
        chk("pri_clr_wrap", 32'(wrap), 0);
        clr = 1'b0;
        tick();
        chk("pri_load_cnt", 32'(cnt), 2);
        load = 1'b0;
        tick();
        chk("pri_after", 32'(cnt), 3);

        // Async reset mid-run
        load     = 1'b1;
        load_val = 3'd6;
        tick();
        load = 1'b0;
        en   = 1'b0;
        chk("async_pre", 32'(cnt), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cnt", 32'(cnt), 0);
        chk("async_zero", 32'(zero), 1);
        chk("async_wrap", 32'(wrap), 0);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        chk("async_resume", 32'(cnt), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
